// File: rtl/accel_dma_pkg.sv
// Shared types and constants for the accelerator DMA read-channel arbiter.
package accel_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_e;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_C = 2;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_DATA_W  = 256;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search begins at ptr and wraps around.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  int   cand;
  logic found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/accel_dma_arbiter.sv
// Round-robin sharing of the single DMA read channel between operand fetchers:
// one burst per grant, beats steered to the owner with per-beat backpressure.
module accel_dma_arbiter
  import accel_dma_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        beat_valid,
  input  logic [NUM_REQ-1:0]        beat_ready,
  output logic [DATA_W-1:0]         beat_data,
  output logic [NUM_REQ-1:0]        done,
  output logic                      dma_start,
  output logic [ADDR_W-1:0]         dma_addr,
  output logic [LEN_W-1:0]          dma_burst_len,
  input  logic                      dma_valid,
  output logic                      dma_ready,
  input  logic [DATA_W-1:0]         dma_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0]  win_oh;
  logic                any_req;
  logic [LEN_W-1:0]    beat_cnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = sel_len  | req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // gnt is one-hot during a burst, so it doubles as the owner select.
  assign dma_ready  = (state == DATA) && |(beat_ready & gnt);
  assign beat_valid = ((state == DATA) && dma_valid) ? gnt : '0;
  assign beat       = dma_valid && dma_ready;
  assign beat_data  = dma_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      done          <= '0;
      dma_start     <= 1'b0;
      dma_addr      <= '0;
      dma_burst_len <= '0;
      beat_cnt      <= '0;
      ptr           <= '0;
    end else begin
      dma_start <= 1'b0;
      done      <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt           <= win_oh;
            dma_addr      <= sel_addr;
            dma_burst_len <= sel_len;
            beat_cnt      <= '0;
            ptr           <= ptr_nxt;
            dma_start     <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= DATA;
        DATA: begin
          if (beat) begin
            // Compare before increment: len = 15 ends on the 16th beat.
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt == dma_burst_len) begin
              done  <= gnt;
              gnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_dma_arbiter.sv
// Directed bench for accel_dma_arbiter: grant order, burst framing, backpressure, reset.
module tb_accel_dma_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 4;
  localparam int DATA_W  = 256;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        beat_valid;
  logic [NUM_REQ-1:0]        beat_ready;
  logic [DATA_W-1:0]         beat_data;
  logic [NUM_REQ-1:0]        done;
  logic                      dma_start;
  logic [ADDR_W-1:0]         dma_addr;
  logic [LEN_W-1:0]          dma_burst_len;
  logic                      dma_valid;
  logic                      dma_ready;
  logic [DATA_W-1:0]         dma_data;

  int n_vec = 0;
  int n_err = 0;

  accel_dma_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .gnt           (gnt),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .beat_data     (beat_data),
    .done          (done),
    .dma_start     (dma_start),
    .dma_addr      (dma_addr),
    .dma_burst_len (dma_burst_len),
    .dma_valid     (dma_valid),
    .dma_ready     (dma_ready),
    .dma_data      (dma_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  // Starts in IDLE with req already driven; runs one full burst with the owner always ready.
  task automatic do_burst(input int exp_idx, input logic [31:0] exp_addr,
                          input int exp_len, input logic [2:0] req_after);
    logic [2:0] oh;
    oh = 3'(3'b001 << exp_idx);
    beat_ready = 3'b111;
    dma_valid  = 1'b0;
    tick();
    n_vec++; if (gnt !== oh) begin n_err++; $display("FAIL grant: gnt=%b expected %b", gnt, oh); end
    n_vec++; if (dma_start !== 1'b1) begin n_err++; $display("FAIL start_hi: dma_start=%b expected 1", dma_start); end
    n_vec++; if (dma_addr !== exp_addr) begin n_err++; $display("FAIL addr: dma_addr=%h expected %h", dma_addr, exp_addr); end
    n_vec++; if (dma_burst_len !== 4'(exp_len)) begin n_err++; $display("FAIL len: dma_burst_len=%0d expected %0d", dma_burst_len, exp_len); end
    req = req_after;
    tick();
    n_vec++; if (dma_start !== 1'b0) begin n_err++; $display("FAIL start_lo: dma_start=%b expected 0", dma_start); end
    for (int b = 0; b <= exp_len; b++) begin
      dma_valid = 1'b1;
      dma_data  = 256'(b + 1) | (256'(exp_idx) << 128);
      #1;
      n_vec++; if (beat_valid !== oh) begin n_err++; $display("FAIL beat_valid: beat %0d got %b expected %b", b, beat_valid, oh); end
      n_vec++; if (dma_ready !== 1'b1) begin n_err++; $display("FAIL dma_ready: beat %0d got %b expected 1", b, dma_ready); end
      n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL early_done: beat %0d done=%b expected 000", b, done); end
      n_vec++; if (beat_data !== dma_data) begin n_err++; $display("FAIL beat_data: beat %0d got %h expected %h", b, beat_data, dma_data); end
      tick();
    end
    dma_valid = 1'b0;
    n_vec++; if (done !== oh) begin n_err++; $display("FAIL done: done=%b expected %b", done, oh); end
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL release: gnt=%b expected 000", gnt); end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req        = '0;
    req_addr   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    req_len    = '0;
    beat_ready = 3'b111;
    dma_valid  = 1'b1;
    dma_data   = 256'h5A;
    tick();
    tick();
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b expected 000", gnt); end
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL rst_done: got %b expected 000", done); end
    n_vec++; if (dma_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b expected 0", dma_start); end
    n_vec++; if (dma_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", dma_addr); end
    n_vec++; if (dma_burst_len !== 4'h0) begin n_err++; $display("FAIL rst_len: got %0d expected 0", dma_burst_len); end
    n_vec++; if (dma_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", dma_ready); end
    n_vec++; if (beat_valid !== 3'b000) begin n_err++; $display("FAIL rst_beat_valid: got %b expected 000", beat_valid); end
    rst       = 1'b0;
    dma_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_len = {4'd0, 4'd0, 4'd1};
    req     = 3'b001;
    do_burst(0, 32'h1000, 1, 3'b000);
    tick();
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_idle_gnt: got %b expected 000", gnt); end
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL single_done_once: got %b expected 000", done); end
    n_vec++; if (dma_start !== 1'b0) begin n_err++; $display("FAIL single_no_restart: got %b expected 0", dma_start); end
  endtask

  task automatic test_contention();
    pulse_reset();
    req_len = '0;
    req     = 3'b111;
    do_burst(0, 32'h1000, 0, 3'b111);
    do_burst(1, 32'h2000, 0, 3'b111);
    do_burst(2, 32'h3000, 0, 3'b111);
    do_burst(0, 32'h1000, 0, 3'b000);
    tick();
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL cont_idle: gnt=%b expected 000", gnt); end
  endtask

  task automatic test_backpressure();
    int accepted;
    pulse_reset();
    req_len = {4'd0, 4'd3, 4'd0};
    req     = 3'b010;
    tick();
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL bp_grant: gnt=%b expected 010", gnt); end
    n_vec++; if (dma_burst_len !== 4'd3) begin n_err++; $display("FAIL bp_len: got %0d expected 3", dma_burst_len); end
    req = 3'b000;
    tick();
    accepted = 0;
    for (int cyc = 0; cyc < 20 && accepted < 4; cyc++) begin
      beat_ready = (cyc % 2 == 0) ? 3'b010 : 3'b101;
      dma_valid  = 1'b1;
      dma_data   = 256'(accepted + 1);
      #1;
      n_vec++; if (dma_ready !== beat_ready[1]) begin n_err++; $display("FAIL bp_ready: cyc %0d got %b expected %b", cyc, dma_ready, beat_ready[1]); end
      n_vec++; if (beat_valid !== 3'b010) begin n_err++; $display("FAIL bp_valid: cyc %0d got %b expected 010", cyc, beat_valid); end
      n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL bp_early_done: cyc %0d got %b expected 000", cyc, done); end
      if (beat_ready[1]) begin
        n_vec++; if (beat_data !== 256'(accepted + 1)) begin n_err++; $display("FAIL bp_data: got %0d expected %0d", beat_data, accepted + 1); end
        accepted++;
      end
      tick();
    end
    dma_valid  = 1'b0;
    beat_ready = 3'b111;
    n_vec++; if (accepted != 4) begin n_err++; $display("FAIL bp_timeout: accepted %0d expected 4", accepted); end
    n_vec++; if (done !== 3'b010) begin n_err++; $display("FAIL bp_done: got %b expected 010", done); end
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL bp_release: got %b expected 000", gnt); end
  endtask

  task automatic test_max_len();
    req_len = {4'd0, 4'd0, 4'd15};
    req     = 3'b001;
    do_burst(0, 32'h1000, 15, 3'b000);
    dma_valid  = 1'b1;
    beat_ready = 3'b111;
    #1;
    n_vec++; if (dma_ready !== 1'b0) begin n_err++; $display("FAIL stray_ready: got %b expected 0", dma_ready); end
    n_vec++; if (beat_valid !== 3'b000) begin n_err++; $display("FAIL stray_valid: got %b expected 000", beat_valid); end
    tick();
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL stray_gnt: got %b expected 000", gnt); end
    n_vec++; if (dma_start !== 1'b0) begin n_err++; $display("FAIL stray_start: got %b expected 0", dma_start); end
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL stray_done: got %b expected 000", done); end
    dma_valid = 1'b0;
  endtask

  task automatic test_req_drop();
    pulse_reset();
    req_len = {4'd1, 4'd0, 4'd0};
    req     = 3'b100;
    do_burst(2, 32'h3000, 1, 3'b001);
    do_burst(0, 32'h1000, 0, 3'b000);
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req_len = {4'd0, 4'd0, 4'd7};
    req     = 3'b001;
    tick();
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL mid_grant: got %b expected 001", gnt); end
    req = 3'b000;
    tick();
    dma_valid  = 1'b1;
    beat_ready = 3'b111;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL mid_gnt: got %b expected 000", gnt); end
    n_vec++; if (beat_valid !== 3'b000) begin n_err++; $display("FAIL mid_valid: got %b expected 000", beat_valid); end
    n_vec++; if (dma_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b expected 0", dma_ready); end
    n_vec++; if (dma_addr !== 32'h0) begin n_err++; $display("FAIL mid_addr: got %h expected 0", dma_addr); end
    n_vec++; if (dma_burst_len !== 4'h0) begin n_err++; $display("FAIL mid_len: got %0d expected 0", dma_burst_len); end
    rst       = 1'b0;
    dma_valid = 1'b0;
    tick();
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL mid_done: got %b expected 000", done); end
    req_len = '0;
    req     = 3'b011;
    do_burst(0, 32'h1000, 0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_max_len();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
